// File: rtl/axis_oq_pkg.sv
// axis_oq_pkg: shared state encoding, clog2 and stored-word field offsets
package axis_oq_pkg;
  typedef enum logic [1:0] {SOP, PASS, DROP} state_t;
  localparam int DATA_LSB = 0;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int strb_lsb(input int data_w);
    return data_w;
  endfunction
  function automatic int oq_lsb(input int data_w, input int strb_f_w);
    return data_w + strb_f_w;
  endfunction
  function automatic int last_bit(input int data_w, input int strb_f_w, input int oq_w);
    return data_w + strb_f_w + oq_w;
  endfunction
endpackage

// File: rtl/axis_oq_sync_fifo.sv
// axis_oq_sync_fifo: DEPTH x W synchronous FIFO with registered read word and exact count
module axis_oq_sync_fifo
  import axis_oq_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 32,
  localparam int AW   = clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [W-1:0]  rd_data,
  output logic [PW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic valid_q, valid_d, push, pop;
  logic [W-1:0] data_q;
  always_comb begin
    full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push = wr_en & ~full;
    pop = rd_en & valid_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    // only words committed before this edge are readable from the array
    valid_d = wr_ptr_q != rd_ptr_d;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q <= valid_d;
      data_q <= mem_q[rd_ptr_d[AW-1:0]];
    end
  end
  assign rd_valid = valid_q;
  assign rd_data = data_q;
  assign count = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/axis_oq_word_fifo.sv
// axis_oq_word_fifo: AXIS ingress buffer tagging words with output queue; AXIS_OQ_STRB_ENCODE_EN stores byte counts
module axis_oq_word_fifo
  import axis_oq_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int USER_W  = 128,
  parameter int NUM_OQ  = 5,
  parameter int DST_LSB = 24,
  parameter int DEPTH   = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OQ_W   = clog2(NUM_OQ),
  localparam int CNT_W  = clog2(DEPTH) + 1,
`ifdef AXIS_OQ_STRB_ENCODE_EN
  localparam int SF_W   = clog2(STRB_W) + 1
`else
  localparam int SF_W   = STRB_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [STRB_W-1:0] s_tstrb,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tlast,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [SF_W-1:0]   m_strb,
  output logic              m_last,
  output logic [OQ_W-1:0]   m_oq,
  input  logic              output_enable,
  output logic [CNT_W-1:0]  fifo_count,
  output logic [15:0]       drop_count
`ifdef AXIS_OQ_STRB_ENCODE_EN
  , output logic            strb_err
`endif
);
  localparam int W        = DATA_W + SF_W + OQ_W + 1;
  localparam int STRB_LSB = strb_lsb(DATA_W);
  localparam int OQ_LSB   = oq_lsb(DATA_W, SF_W);
  localparam int LAST_BIT = last_bit(DATA_W, SF_W, OQ_W);
  state_t state_q, state_d;
  logic [OQ_W-1:0] oq_q, oq_d, dst_oq;
  logic [15:0] drop_q, drop_d;
  logic [NUM_OQ-1:0] field;
  logic [SF_W-1:0] strb_f;
  logic [W-1:0] wr_word, rd_word;
  logic beat, push, full, pop, rd_valid;
  logic unused_tuser;
  assign unused_tuser = ^s_tuser;
  always_comb begin
    field = s_tuser[DST_LSB +: NUM_OQ];
    dst_oq = '0;
    for (int i = NUM_OQ - 1; i >= 0; i--) if (field[i]) dst_oq = OQ_W'(i);
  end
`ifdef AXIS_OQ_STRB_ENCODE_EN
  logic strb_ok, strb_err_q, strb_err_d;
  always_comb begin
    strb_ok = (s_tstrb & (s_tstrb + STRB_W'(1))) == '0;
    strb_f = strb_ok ? SF_W'($countones(s_tstrb)) : '0;
    strb_err_d = strb_err_q | (push & ~strb_ok);
  end
  assign strb_err = strb_err_q;
`else
  assign strb_f = s_tstrb;
`endif
  always_comb begin
    s_tready = ~reset & ((state_q == DROP) | ~full);
    beat = s_tvalid & s_tready;
    state_d = state_q;
    oq_d = oq_q;
    drop_d = drop_q;
    push = 1'b0;
    if (beat) begin
      if (state_q == SOP) begin
        push = field != '0;
        oq_d = push ? dst_oq : oq_q;
        drop_d = (push || drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
        state_d = s_tlast ? SOP : (push ? PASS : DROP);
      end else begin
        push = state_q == PASS;
        state_d = s_tlast ? SOP : state_q;
      end
    end
    wr_word = {s_tlast, (state_q == SOP) ? dst_oq : oq_q, strb_f, s_tdata};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SOP;
      oq_q <= '0;
      drop_q <= '0;
`ifdef AXIS_OQ_STRB_ENCODE_EN
      strb_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      oq_q <= oq_d;
      drop_q <= drop_d;
`ifdef AXIS_OQ_STRB_ENCODE_EN
      strb_err_q <= strb_err_d;
`endif
    end
  end
  axis_oq_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (wr_word),
    .full     (full),
    .rd_en    (pop),
    .rd_valid (rd_valid),
    .rd_data  (rd_word),
    .count    (fifo_count)
  );
  assign m_valid = rd_valid & output_enable;
  assign pop = m_valid & m_ready;
  assign m_data = rd_word[DATA_LSB +: DATA_W];
  assign m_strb = rd_word[STRB_LSB +: SF_W];
  assign m_oq = rd_word[OQ_LSB +: OQ_W];
  assign m_last = rd_word[LAST_BIT];
  assign drop_count = drop_q;
endmodule

// File: tb/tb_axis_oq_word_fifo.sv
// tb_axis_oq_word_fifo: directed plus random stimulus against a queue-based packet model
module tb_axis_oq_word_fifo;
  localparam int DATA_W = 256, USER_W = 128, NUM_OQ = 5, DST_LSB = 24, DEPTH = 32;
  localparam int STRB_W = 32, OQ_W = 3, CNT_W = 6;
`ifdef AXIS_OQ_STRB_ENCODE_EN
  localparam int SF_W = 6;
`else
  localparam int SF_W = STRB_W;
`endif
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [SF_W-1:0] strb;
    int oq;
    bit last;
    int t_push;
  } word_t;
  logic clk = 0, reset = 1;
  logic s_tvalid, s_tready, s_tlast, m_valid, m_ready, m_last, output_enable;
  logic [DATA_W-1:0] s_tdata, m_data;
  logic [STRB_W-1:0] s_tstrb;
  logic [USER_W-1:0] s_tuser;
  logic [SF_W-1:0] m_strb;
  logic [OQ_W-1:0] m_oq;
  logic [CNT_W-1:0] fifo_count;
  logic [15:0] drop_count;
  logic strb_err;
  word_t q[$];
  int mst, moq, drops, ecount, npop, ncmp, nbad, k, base;
  bit m_err, acc, popped;
  always #5 clk = ~clk;
  axis_oq_word_fifo dut (
    .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tuser(s_tuser), .s_tlast(s_tlast), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_strb(m_strb), .m_last(m_last), .m_oq(m_oq), .output_enable(output_enable),
`ifdef AXIS_OQ_STRB_ENCODE_EN
    .strb_err(strb_err),
`endif
    .fifo_count(fifo_count), .drop_count(drop_count)
  );
`ifndef AXIS_OQ_STRB_ENCODE_EN
  assign strb_err = 1'b0;
`endif
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [USER_W-1:0] user_of(input logic [NUM_OQ-1:0] f);
    logic [USER_W-1:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[DST_LSB +: NUM_OQ] = f;
    return u;
  endfunction
  function automatic int low_oq(input logic [USER_W-1:0] u);
    logic [NUM_OQ-1:0] f;
    f = u[DST_LSB +: NUM_OQ];
    for (int i = 0; i < NUM_OQ; i++) if (f[i]) return i;
    return -1;
  endfunction
  function automatic bit contig(input logic [STRB_W-1:0] s);
    int n;
    n = $countones(s);
    for (int i = 0; i < STRB_W; i++) if (s[i] != (i < n)) return 0;
    return 1;
  endfunction
  function automatic logic [SF_W-1:0] exp_strb(input logic [STRB_W-1:0] s);
`ifdef AXIS_OQ_STRB_ENCODE_EN
    return contig(s) ? SF_W'($countones(s)) : '0;
`else
    return s;
`endif
  endfunction
  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] st,
                       input logic [USER_W-1:0] u, input bit l);
    s_tvalid = v; s_tdata = d; s_tstrb = st; s_tuser = u; s_tlast = l;
  endtask
  task automatic store(input int o);
    word_t w;
    w.data = s_tdata; w.strb = exp_strb(s_tstrb); w.oq = o; w.last = s_tlast; w.t_push = ecount;
    if (!contig(s_tstrb)) m_err = 1;
    q.push_back(w);
  endtask
  task automatic model_beat();
    int o;
    o = low_oq(s_tuser);
    if (mst == 0) begin
      if (o >= 0) begin store(o); moq = o; mst = s_tlast ? 0 : 1; end
      else begin if (drops < 65535) drops++; mst = s_tlast ? 0 : 2; end
    end else if (mst == 1) begin
      store(moq);
      if (s_tlast) mst = 0;
    end else if (s_tlast) mst = 0;
  endtask
  task automatic tick();
    bit etr, ev;
    #1;
    etr = !reset && (mst == 2 || q.size() < DEPTH);
    ev = q.size() > 0 && q[0].t_push <= ecount - 1 && output_enable;
    if (!reset) begin
      check("s_tready", s_tready, etr);
      check("m_valid", m_valid, ev);
      check("fifo_count", fifo_count, q.size());
      check("drop_count", drop_count, drops);
`ifdef AXIS_OQ_STRB_ENCODE_EN
      check("strb_err", strb_err, m_err);
`endif
      if (ev) begin
        check("m_data", m_data, q[0].data);
        check("m_strb", m_strb, q[0].strb);
        check("m_oq", m_oq, q[0].oq);
        check("m_last", m_last, q[0].last);
      end
    end
    acc = etr && s_tvalid;
    popped = ev && m_ready;
    @(posedge clk);
    ecount++;
    if (reset) begin
      q.delete(); mst = 0; drops = 0; m_err = 0;
    end else begin
      if (popped) begin void'(q.pop_front()); npop++; end
      if (acc) model_beat();
    end
    @(negedge clk);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    drive(0, '0, '0, '0, 0);
    m_ready = 1; output_enable = 1;
    @(negedge clk);
    tick(); tick();
    reset = 0;
    // two back-to-back packets, the first with tuser[31:24] = 8'b10101111
    drive(1, 50, '1, user_of(5'b01111), 0); tick();
    drive(1, 51, '1, user_of(5'b01111), 1); tick();
    drive(1, 200, '1, user_of(5'b01010), 0); tick();
    drive(1, 201, '1, user_of(5'b01010), 1); tick();
    s_tvalid = 0;
    repeat (5) tick();
    check("idle_count", fifo_count, 0);
    for (int i = 0; i < 3; i++) begin drive(1, rnd256(), '1, user_of('0), i == 2); tick(); end
    s_tvalid = 0;
    repeat (3) tick();
    check("drop_one", drop_count, 1);
    // fill with output disabled, then drain with a toggling ready
    output_enable = 0; k = 0;
    for (int c = 0; c < 60; c++) begin
      drive(1, 1000 + k, '1, user_of(NUM_OQ'(1 << (k % NUM_OQ))), 1);
      tick();
      if (acc) k++;
    end
    s_tvalid = 0;
    check("fill_acc", k, 32);
    check("fill_cnt", fifo_count, 32);
    check("fill_rdy", s_tready, 0);
    output_enable = 1; base = npop;
    for (int c = 0; c < 400 && npop - base < 40; c++) begin
      m_ready = c[0];
      if (k < 40) drive(1, 1000 + k, '1, user_of(NUM_OQ'(1 << (k % NUM_OQ))), 1);
      else s_tvalid = 0;
      tick();
      if (acc) k++;
    end
    check("drained", npop - base, 40);
    m_ready = 1;
    // reset while mid-packet with five words held
    output_enable = 0;
    for (int i = 0; i < 5; i++) begin drive(1, 300 + i, '1, user_of(5'b00100), 0); tick(); end
    s_tvalid = 0; tick();
    check("pre_rst_cnt", fifo_count, 5);
    reset = 1; tick(); reset = 0;
    check("rst_cnt", fifo_count, 0);
    check("rst_valid", m_valid, 0);
    output_enable = 1;
    drive(1, 400, '1, user_of(5'b10000), 0); tick();
    drive(1, 401, '1, user_of(5'b10000), 1); tick();
    drive(1, 500, 32'h0000FFFF, user_of(5'b00010), 1); tick();
    drive(1, 501, 32'h00000F0F, user_of(5'b00010), 1); tick();
    s_tvalid = 0;
    repeat (5) tick();
`ifdef AXIS_OQ_STRB_ENCODE_EN
    check("strb_err_set", strb_err, 1);
`endif
    for (int c = 0; c < 1500; c++) begin
      logic [NUM_OQ-1:0] f;
      f = NUM_OQ'($urandom);
      if ($urandom % 6 == 0) f = '0;
      drive($urandom % 4 != 0, rnd256(), ($urandom % 4 == 0) ? STRB_W'($urandom) : '1,
            user_of(f), $urandom % 3 == 0);
      m_ready = $urandom % 4 != 0;
      output_enable = $urandom % 8 != 0;
      tick();
    end
    s_tvalid = 0; m_ready = 1; output_enable = 1;
    repeat (40) tick();
    check("final_cnt", fifo_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/axis_oq_word_fifo.md
Name: axis_oq_word_fifo

Overview:
Parametrised single-clock ingress buffer for the SRAM output-queue path. It accepts AXI4-Stream packets, resolves each packet's destination output queue from the tuser destination field, and tags every stored word with that queue index. It buffers the words in a DEPTH-entry FIFO and presents them to the SRAM write arbiter through a valid/ready interface gated by output_enable. Packets with no valid destination are consumed and discarded.

Parameters:
DATA_W, 256, tdata width in bits (multiple of 8)
USER_W, 128, tuser width
NUM_OQ, 5, number of output queues; must satisfy 2..16
DST_LSB, 24, LSB of the NUM_OQ-bit destination field inside tuser
DEPTH, 32, FIFO depth in words; power of 2, at least 4
Derived: STRB_W=DATA_W/8, OQ_W=clog2(NUM_OQ), CNT_W=clog2(DEPTH)+1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
s_tvalid  in  1  slave valid
s_tready  out  1  slave ready
s_tdata  in  DATA_W  packet data
s_tstrb  in  STRB_W  byte strobes
s_tuser  in  USER_W  metadata; destination one-hot at [DST_LSB +: NUM_OQ]
s_tlast  in  1  last beat of packet
m_valid  out  1  word available
m_ready  in  1  arbiter accepts word
m_data  out  DATA_W  word data
m_strb  out  STRB_W (see Optional Feature)  word strobes
m_last  out  1  last word of packet
m_oq  out  OQ_W  destination queue of word
output_enable  in  1  downstream enable; 0 holds m_valid low
fifo_count  out  CNT_W  words currently stored
drop_count  out  16  packets discarded, saturating

Behaviour:
- Reset: all outputs 0, FIFO empty, state SOP. Reset mid-packet flushes stored words and any partial packet.
- A beat transfers when s_tvalid & s_tready.
- Input FSM:
  - SOP: on the first beat, field = s_tuser[DST_LSB +: NUM_OQ]. If field != 0, oq_lat = index of the lowest set bit. This beat is written, go to PASS, or stay in SOP if s_tlast. If field == 0, discard the beat, go to DROP (stay in SOP if s_tlast), and increment drop_count at that beat.
  - PASS: every beat is written with oq_lat. s_tlast returns to SOP.
  - DROP: beats are discarded. s_tlast returns to SOP.
- s_tready = ~full in SOP and PASS. s_tready = 1 in DROP. s_tready = 0 during reset.
- Stored word = {last, oq, strb, data}.
- Output is registered. A word written at edge N is visible on m_* after edge N+1 at the earliest.
- m_valid = nonempty & output_enable. A pop happens on m_valid & m_ready.
- m_* stay stable while m_valid & ~m_ready.
- Dropping output_enable while m_valid is high holds the word; no word is lost.
- Simultaneous push and pop when full: the push is refused, because s_tready is computed from the registered full flag. Simultaneous push and pop when nonempty: count is unchanged.
- fifo_count is exact every cycle and wraps correctly at DEPTH. Pointers are clog2(DEPTH)+1 bits; full/empty use the MSB compare.
- drop_count saturates at 16'hFFFF.

Optional Feature:
Macro: AXIS_OQ_STRB_ENCODE_EN.
- Defined: m_strb is replaced by a clog2(STRB_W)+1-bit valid-byte count (popcount of s_tstrb, contiguous LSB strobes required). This narrows the stored word. A beat with non-contiguous strobes is stored with count 0 and sets a sticky output strb_err, which clears only on reset.
- Undefined: m_strb carries raw tstrb; port strb_err does not exist.

Decomposition:
- Package axis_oq_pkg: state enum {SOP, PASS, DROP}, the clog2 function, and the word field-offset localparams.
- One sub-module: axis_oq_sync_fifo, a generic DEPTH x W synchronous FIFO with registered output and count.
- Parser FSM, priority encoder and drop counter live in the top level.

Test Plan:
- 2-beat packet, tdata 50, tuser[31:24]=8'b10101111 (DST_LSB=24, field 5'b01111), output_enable=1 -> two words, data 50 then 51, m_oq=0, m_last on word 2, first m_valid 2 cycles after the first beat.
- Back-to-back packet, tdata 200, field 5'b01010 -> m_oq=1 on both words; fifo_count returns to 0.
- Field 0 on a 3-beat packet -> s_tready stays 1, no words stored, drop_count=1.
- output_enable=0, stream 40 single-beat packets -> s_tready low after 32 accepted, fifo_count=32. Then output_enable=1 with m_ready toggling every cycle -> all 40 words delivered in order, none duplicated.
- Assert reset while in PASS with 5 words stored -> next cycle fifo_count=0, m_valid=0, state SOP; the next packet is parsed correctly.
- With AXIS_OQ_STRB_ENCODE_EN: tstrb=32'h0000FFFF -> m_strb=16. tstrb=32'h00000F0F -> strb_err=1.
